wb_regfile: RTL and testbench

- Write-back stage plus general register file (GRF) of the 5-stage MIPS datapath.
- Consumes the registered outputs of the MEM/WB pipeline register.
- Performs load-data extraction/extension and the MemtoReg write-data select, then commits to a 32x32 register file.
- Exposes two combinational read ports to the ID stage, with same-cycle write-through, plus the WB forwarding triple for the hazard unit.

---
 rtl/wb_regfile.sv | 101 ++++++++++
 tb/tb_wb_regfile.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// MIPS write-back stage: load extraction/extension, write-data select, and a
// 32x32 register file with two combinational read ports and write-through bypass.
module wb_regfile #(
  parameter logic [31:0] SP_INIT = 32'h0000_2ffc,
  parameter logic [31:0] GP_INIT = 32'h0000_1800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  MemtoReg,
  input  logic        RegWrite,
  input  logic [31:0] dmOut,
  input  logic [31:0] ALUS,
  input  logic [4:0]  WReg,
  input  logic [31:0] pc8,
  input  logic [2:0]  load_ext_op,
  input  logic [31:0] HILO,
  input  logic [31:0] CP0Out,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [31:0] wb_count
);

  // Register 0 has no storage; reads of it are forced to zero below.
  logic [31:0] regs [1:31];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  always_comb begin
    byte_sel = dmOut[7:0];
    case (ALUS[1:0])
      2'd1:    byte_sel = dmOut[15:8];
      2'd2:    byte_sel = dmOut[23:16];
      2'd3:    byte_sel = dmOut[31:24];
      default: byte_sel = dmOut[7:0];
    endcase
    half_sel = ALUS[1] ? dmOut[31:16] : dmOut[15:0];
  end

  always_comb begin
    load_data = dmOut;
    case (load_ext_op)
      3'd1:    load_data = {24'd0, byte_sel};
      3'd2:    load_data = {{24{byte_sel[7]}}, byte_sel};
      3'd3:    load_data = {16'd0, half_sel};
      3'd4:    load_data = {{16{half_sel[15]}}, half_sel};
      default: load_data = dmOut;
    endcase
  end

  always_comb begin
    wb_data = ALUS;
    case (MemtoReg)
      3'd1:    wb_data = load_data;
      3'd2:    wb_data = pc8;
      3'd3:    wb_data = HILO;
      3'd4:    wb_data = CP0Out;
      default: wb_data = ALUS;
    endcase
  end

  assign wb_we   = RegWrite && (WReg != 5'd0);
  assign wb_addr = WReg;

  // Same-cycle bypass lets ID see the value being committed this cycle.
  always_comb begin
    rdata1 = 32'd0;
    if (raddr1 != 5'd0) begin
      if (wb_we && (WReg == raddr1)) rdata1 = wb_data;
      else                           rdata1 = regs[raddr1];
    end
  end

  always_comb begin
    rdata2 = 32'd0;
    if (raddr2 != 5'd0) begin
      if (wb_we && (WReg == raddr2)) rdata2 = wb_data;
      else                           rdata2 = regs[raddr2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        if (i == 28)      regs[i] <= GP_INIT;
        else if (i == 29) regs[i] <= SP_INIT;
        else              regs[i] <= 32'd0;
      end
      wb_count <= 32'd0;
    end else if (wb_we) begin
      regs[WReg] <= wb_data;
      wb_count   <= wb_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset contents, load extension, source
// select, zero register, write-through bypass and the commit counter.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  MemtoReg = '0;
  logic        RegWrite = 1'b0;
  logic [31:0] dmOut = '0;
  logic [31:0] ALUS = '0;
  logic [4:0]  WReg = '0;
  logic [31:0] pc8 = '0;
  logic [2:0]  load_ext_op = '0;
  logic [31:0] HILO = '0;
  logic [31:0] CP0Out = '0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;
  logic [31:0] rdata1, rdata2, wb_data, wb_count;
  logic        wb_we;
  logic [4:0]  wb_addr;

  wb_regfile dut (
    .clk(clk), .rst(rst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .dmOut(dmOut), .ALUS(ALUS), .WReg(WReg), .pc8(pc8),
    .load_ext_op(load_ext_op), .HILO(HILO), .CP0Out(CP0Out),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_count(wb_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_count = 32'd0;

  typedef struct {
    logic [2:0]  m2r;
    logic [2:0]  ext;
    logic [31:0] alus;
    logic [4:0]  wreg;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  // driver: present one MEM/WB record at a negedge
  task automatic drive(input logic [2:0] m, input logic [2:0] e, input logic we,
                       input logic [31:0] a, input logic [4:0] w);
    @(negedge clk);
    MemtoReg = m; load_ext_op = e; RegWrite = we; ALUS = a; WReg = w;
    raddr1 = w; raddr2 = w;
  endtask

  // commit on the next rising edge, then drop RegWrite so reads hit the array
  task automatic commit();
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    #1;
  endtask

  initial begin
    dmOut  = 32'h8070_F0A5;
    pc8    = 32'h0000_3008;
    HILO   = 32'hAABB_CCDD;
    CP0Out = 32'h1357_2468;

    vecs[0]  = '{3'd1, 3'd2, 32'h0000_0000, 5'd8,  32'hFFFF_FFA5}; // lb  off0
    vecs[1]  = '{3'd1, 3'd1, 32'h0000_0001, 5'd8,  32'h0000_00F0}; // lbu off1
    vecs[2]  = '{3'd1, 3'd4, 32'h0000_0002, 5'd8,  32'hFFFF_8070}; // lh  off2
    vecs[3]  = '{3'd1, 3'd3, 32'h0000_0000, 5'd8,  32'h0000_F0A5}; // lhu off0
    vecs[4]  = '{3'd1, 3'd2, 32'h0000_0003, 5'd9,  32'hFFFF_FF80}; // lb  off3
    vecs[5]  = '{3'd1, 3'd1, 32'h0000_0002, 5'd10, 32'h0000_0070}; // lbu off2
    vecs[6]  = '{3'd1, 3'd4, 32'h0000_0000, 5'd11, 32'hFFFF_F0A5}; // lh  off0
    vecs[7]  = '{3'd1, 3'd3, 32'h0000_0003, 5'd16, 32'h0000_8070}; // lhu off3
    vecs[8]  = '{3'd1, 3'd0, 32'h0000_0100, 5'd17, 32'h8070_F0A5}; // lw
    vecs[9]  = '{3'd1, 3'd6, 32'h0000_0003, 5'd18, 32'h8070_F0A5}; // ext 6
    vecs[10] = '{3'd2, 3'd0, 32'h0000_0F00, 5'd31, 32'h0000_3008}; // link
    vecs[11] = '{3'd3, 3'd0, 32'h0000_0F00, 5'd12, 32'hAABB_CCDD}; // HILO
    vecs[12] = '{3'd4, 3'd0, 32'h0000_0F00, 5'd13, 32'h1357_2468}; // CP0
    vecs[13] = '{3'd6, 3'd1, 32'h0BAD_F00D, 5'd14, 32'h0BAD_F00D}; // m2r 6
    vecs[14] = '{3'd0, 3'd2, 32'h1111_1111, 5'd15, 32'h1111_1111}; // m2r 0
    vecs[15] = '{3'd7, 3'd0, 32'h2222_2222, 5'd19, 32'h2222_2222}; // m2r 7

    // Reset asserted mid-cycle, then read its contents.
    #3 rst = 1'b1;
    #1;
    raddr1 = 5'd28; raddr2 = 5'd29;
    #1;
    check("rst_r28", rdata1, 32'h0000_1800);
    check("rst_r29", rdata2, 32'h0000_2ffc);
    raddr1 = 5'd5;
    #1;
    check("rst_r5", rdata1, 32'd0);
    check("rst_count", wb_count, 32'd0);

    // A write requested under reset bypasses but does not commit.
    drive(3'd0, 3'd0, 1'b1, 32'h0000_0055, 5'd5);
    #1;
    check("rst_bypass", rdata1, 32'h0000_0055);
    commit();
    check("rst_no_write", rdata1, 32'd0);
    check("rst_no_count", wb_count, 32'd0);

    // Deassert between edges; the next edge commits normally.
    @(negedge clk);
    #2 rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].m2r, vecs[i].ext, 1'b1, vecs[i].alus, vecs[i].wreg);
      #1;
      check($sformatf("v%0d_wb_data", i), wb_data, vecs[i].exp);
      check($sformatf("v%0d_wb_we", i), {31'd0, wb_we}, 32'd1);
      check($sformatf("v%0d_bypass", i), rdata1, vecs[i].exp);
      exp_q.push_back(vecs[i].exp);
      exp_count++;
      commit();
      check($sformatf("v%0d_readback", i), rdata2, exp_q.pop_front());
      check($sformatf("v%0d_count", i), wb_count, exp_count);
    end
    check("wb_addr", {27'd0, wb_addr}, 32'd19);
    raddr1 = 5'd28; raddr2 = 5'd29;
    #1;
    check("gp_intact", rdata1, 32'h0000_1800);
    check("sp_intact", rdata2, 32'h0000_2ffc);

    // Register 0: no write, no count, reads zero.
    drive(3'd0, 3'd0, 1'b1, 32'hDEAD_BEEF, 5'd0);
    #1;
    check("r0_we", {31'd0, wb_we}, 32'd0);
    check("r0_read", rdata1, 32'd0);
    commit();
    check("r0_count", wb_count, exp_count);
    check("r0_after", rdata2, 32'd0);

    // Write-through on both ports, then persistence from the array.
    drive(3'd0, 3'd0, 1'b0, 32'h0000_0000, 5'd7);
    #1;
    check("r7_initial", rdata1, 32'd0);
    drive(3'd0, 3'd0, 1'b1, 32'h1234_5678, 5'd7);
    #1;
    check("wt_port1", rdata1, 32'h1234_5678);
    check("wt_port2", rdata2, 32'h1234_5678);
    exp_count++;
    commit();
    check("wt_held1", rdata1, 32'h1234_5678);
    check("wt_held2", rdata2, 32'h1234_5678);

    // Counter from a fresh reset: three writes and a bubble.
    @(negedge clk);
    rst = 1'b1;
    #2 rst = 1'b0;
    exp_count = 32'd0;
    for (int r = 1; r <= 3; r++) begin
      drive(3'd0, 3'd0, 1'b1, 32'hA000_0000 + r, r[4:0]);
      commit();
    end
    drive(3'd0, 3'd0, 1'b0, 32'h5555_5555, 5'd2);
    #1;
    check("bubble_we", {31'd0, wb_we}, 32'd0);
    commit();
    check("cnt3", wb_count, 32'd3);
    raddr1 = 5'd2; raddr2 = 5'd3;
    #1;
    check("r2_kept", rdata1, 32'hA000_0002);
    check("r3_val", rdata2, 32'hA000_0003);

    // Asynchronous reset clears the count without a clock edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_count", wb_count, 32'd0);
    check("async_r3", rdata2, 32'd0);
    #1 rst = 1'b0;

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
